spike_rate_encoder: RTL and testbench

Converts a 5x5 patch of 8-bit pixel intensities into a deterministic rate-coded spike train, one 25-bit spike vector per timestep `pulse`. It sits upstream of the layer-1 MAC/NCHU neurons and drives their `pixelsIn` spike bus, so each neuron sees the same patch for a fixed window of `NUM_STEPS` timesteps. Each pixel uses a per-pixel phase accumulator, so spike counts are exact and repeatable; no random source is involved.

---
 rtl/spike_rate_encoder.sv | 102 ++++++++++
 tb/tb_spike_rate_encoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_encoder.sv
// Rate-codes a patch of pixel intensities into one spike vector per pulse via per-pixel phase accumulators.
// Latency: 1 cycle from load/pulse to registered outputs; no combinational path from inputs to outputs.
// Backpressure: none; every pulse in RUN is consumed, pulses in IDLE are ignored.
module spike_rate_encoder #(
    parameter int NUM_PIX   = 25,
    parameter int PIX_W     = 8,
    parameter int NUM_STEPS = 16,
    localparam int CNT_W    = $clog2(NUM_STEPS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [NUM_PIX*PIX_W-1:0] intensities_in,
    input  logic                     pulse,
    output logic [NUM_PIX-1:0]       spk_pixels,
    output logic                     frame_start,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         step_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PIX_W-1:0] HALF = {1'b1, {(PIX_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_STEPS - 1);

    state_t                          state;
    logic [NUM_PIX-1:0][PIX_W-1:0]   acc;
    logic [NUM_PIX-1:0][PIX_W-1:0]   inten;
    logic [NUM_PIX-1:0][PIX_W:0]     sum;
    logic [NUM_PIX-1:0][PIX_W-1:0]   acc_nxt;
    logic [NUM_PIX-1:0]              carry;

    // The carry out of each phase accumulator is that pixel's spike for the step.
    always_comb begin
        sum     = '0;
        acc_nxt = '0;
        carry   = '0;
        for (int i = 0; i < NUM_PIX; i++) begin
            sum[i]     = {1'b0, acc[i]} + {1'b0, inten[i]};
            carry[i]   = sum[i][PIX_W];
            acc_nxt[i] = sum[i][PIX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            spk_pixels  <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            step_cnt    <= '0;
            acc         <= {NUM_PIX{HALF}};
            inten       <= '0;
        end else begin
            frame_start <= 1'b0;
            if (load) begin
                inten       <= intensities_in;
                acc         <= {NUM_PIX{HALF}};
                spk_pixels  <= '0;
                step_cnt    <= '0;
                state       <= RUN;
                busy        <= 1'b1;
                done        <= 1'b0;
                frame_start <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (pulse) begin
                            acc        <= acc_nxt;
                            spk_pixels <= carry;
                            step_cnt   <= step_cnt + CNT_W'(1);
                            if (step_cnt == LAST) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    // Last vector stays up until the neurons have sampled it on one more pulse.
                    DONE: begin
                        if (pulse) begin
                            spk_pixels <= '0;
                            state      <= IDLE;
                            done       <= 1'b0;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        spk_pixels <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Scoreboarded bench for spike_rate_encoder: a floor-arithmetic window model predicts every cycle's outputs.
module tb_spike_rate_encoder;

    localparam int NP = 25;
    localparam int PW = 8;
    localparam int NS = 16;
    localparam int CW = $clog2(NS + 1);
    localparam int DW = NP * PW;

    typedef struct packed {
        logic [NP-1:0] spk;
        logic          fs;
        logic          busy;
        logic          done;
        logic [CW-1:0] cnt;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset, load, pulse;
    logic [DW-1:0] intensities_in;
    logic [NP-1:0] spk_pixels;
    logic          frame_start, busy, done;
    logic [CW-1:0] step_cnt;

    logic          reset1, load1, pulse1;
    logic [DW-1:0] intensities1;
    logic [NP-1:0] spk1;
    logic          fs1, busy1, done1;
    logic [0:0]    cnt1;

    int vectors    = 0;
    int miscompares = 0;
    obs_t exp_q[$];

    // model state
    int            m_mode;   // 0 idle, 1 run, 2 done
    int            m_k;
    int            m_int[NP];
    logic [NP-1:0] m_spk;
    bit            m_fs;

    always #5 clk = ~clk;

    spike_rate_encoder #(.NUM_PIX(NP), .PIX_W(PW), .NUM_STEPS(NS)) dut (
        .clk(clk), .reset(reset), .load(load), .intensities_in(intensities_in),
        .pulse(pulse), .spk_pixels(spk_pixels), .frame_start(frame_start),
        .busy(busy), .done(done), .step_cnt(step_cnt)
    );

    spike_rate_encoder #(.NUM_PIX(NP), .PIX_W(PW), .NUM_STEPS(1)) dut1 (
        .clk(clk), .reset(reset1), .load(load1), .intensities_in(intensities1),
        .pulse(pulse1), .spk_pixels(spk1), .frame_start(fs1),
        .busy(busy1), .done(done1), .step_cnt(cnt1)
    );

    // Step k spikes iff the running count floor((128 + k*I)/256) advances.
    function automatic bit spikes_at(input int inten, input int k);
        return ((128 + k * inten) / 256) != ((128 + (k - 1) * inten) / 256);
    endfunction

    function automatic logic [DW-1:0] rand_patch();
        logic [DW-1:0] d;
        for (int i = 0; i < NP; i++) d[i*PW +: PW] = PW'($urandom_range(0, 255));
        return d;
    endfunction

    function automatic logic [DW-1:0] flat_patch(input int v);
        logic [DW-1:0] d;
        for (int i = 0; i < NP; i++) d[i*PW +: PW] = PW'(v);
        return d;
    endfunction

    task automatic model(input bit r, input bit l, input bit p, input logic [DW-1:0] d);
        m_fs = 1'b0;
        if (r) begin
            m_mode = 0; m_k = 0; m_spk = '0;
            for (int i = 0; i < NP; i++) m_int[i] = 0;
        end else if (l) begin
            for (int i = 0; i < NP; i++) m_int[i] = int'(d[i*PW +: PW]);
            m_mode = 1; m_k = 0; m_spk = '0; m_fs = 1'b1;
        end else if (m_mode == 1 && p) begin
            m_k++;
            for (int i = 0; i < NP; i++) m_spk[i] = spikes_at(m_int[i], m_k);
            if (m_k == NS) m_mode = 2;
        end else if (m_mode == 2 && p) begin
            m_spk = '0; m_mode = 0;
        end
    endtask

    task automatic cycle(input bit r, input bit l, input bit p, input logic [DW-1:0] d);
        obs_t e;
        reset = r; load = l; pulse = p; intensities_in = d;
        @(posedge clk);
        model(r, l, p, d);
        e.spk = m_spk; e.fs = m_fs; e.busy = (m_mode == 1); e.done = (m_mode == 2);
        e.cnt = CW'(m_k);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: the DUT presents a fresh registered vector every cycle.
    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {spk_pixels, frame_start, busy, done, step_cnt};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL cycle_out @%0t: got spk=%h fs=%b busy=%b done=%b cnt=%0d, expected spk=%h fs=%b busy=%b done=%b cnt=%0d",
                         $time, a.spk, a.fs, a.busy, a.done, a.cnt, e.spk, e.fs, e.busy, e.done, e.cnt);
            end
        end
    end

    initial begin
        logic [DW-1:0] d;
        int            tally[5];
        logic [15:0]   p1_steps;

        reset = 1'b1; load = 1'b0; pulse = 1'b0; intensities_in = '0;
        reset1 = 1'b1; load1 = 1'b0; pulse1 = 1'b0; intensities1 = '0;

        // Single-step build: one full-rate spike, then DONE straight away.
        @(posedge clk); #1;
        chk("n1_reset", {spk1, fs1, busy1, done1, cnt1}, 64'h0);
        reset1 = 1'b0; load1 = 1'b1; intensities1 = flat_patch(255);
        @(posedge clk); #1;
        chk("n1_load", {spk1, fs1, busy1, done1, cnt1}, {25'h0, 1'b1, 1'b1, 1'b0, 1'b0});
        load1 = 1'b0; pulse1 = 1'b1;
        @(posedge clk); #1;
        chk("n1_pulse", {spk1, fs1, busy1, done1, cnt1}, {25'h1FFFFFF, 1'b0, 1'b0, 1'b1, 1'b1});
        pulse1 = 1'b0;
        @(posedge clk); #1;
        chk("n1_hold", {spk1, done1}, {25'h1FFFFFF, 1'b1});

        // Reset state, then uniform 128 patch with pulses every third cycle.
        cycle(1, 0, 0, '0);
        cycle(1, 0, 1, rand_patch());
        cycle(0, 0, 1, '0);
        d = flat_patch(128);
        cycle(0, 1, 0, d);
        for (int s = 1; s <= NS; s++) begin
            cycle(0, 0, 1, d);
            chk("half_step", {39'h0, spk_pixels}, (s % 2) ? 64'h1FFFFFF : 64'h0);
            cycle(0, 0, 0, d);
            cycle(0, 0, 0, d);
        end
        chk("half_done", {63'h0, done}, 64'h1);

        // Mixed patch, back-to-back pulses.
        d = flat_patch(128);
        d[0 +: 8] = 8'd0; d[8 +: 8] = 8'd64; d[16 +: 8] = 8'd255; d[24 +: 8] = 8'd1;
        cycle(0, 1, 0, d);
        for (int i = 0; i < 5; i++) tally[i] = 0;
        p1_steps = '0;
        for (int s = 1; s <= NS; s++) begin
            cycle(0, 0, 1, d);
            for (int i = 0; i < 5; i++) tally[i] += int'(spk_pixels[i]);
            p1_steps[s-1] = spk_pixels[1];
        end
        chk("mix_cnt0", 64'(tally[0]), 64'd0);
        chk("mix_cnt1", 64'(tally[1]), 64'd4);
        chk("mix_cnt2", 64'(tally[2]), 64'd16);
        chk("mix_cnt3", 64'(tally[3]), 64'd0);
        chk("mix_cnt4", 64'(tally[4]), 64'd8);
        chk("mix_p1_steps", 64'(p1_steps), 64'h2222);

        // DONE holds the last vector, first pulse drops to IDLE, IDLE ignores pulses and new data.
        repeat (3) cycle(0, 0, 0, d);
        cycle(0, 0, 1, d);
        chk("done_clear", {spk_pixels, done}, 64'h0);
        repeat (5) cycle(0, 0, 1, rand_patch());
        chk("idle_spk", {39'h0, spk_pixels}, 64'h0);

        // load with pulse in the same cycle, then restart at step 5.
        d = rand_patch();
        cycle(0, 1, 1, d);
        chk("load_pulse_cnt", 64'(step_cnt), 64'd0);
        repeat (5) cycle(0, 0, 1, d);
        d = rand_patch();
        cycle(0, 1, 1, d);
        chk("restart_fs", {63'h0, frame_start}, 64'h1);
        chk("restart_cnt", 64'(step_cnt), 64'd0);
        repeat (NS + 2) cycle(0, 0, 1, d);

        // Reset mid-window with pulse high.
        d = rand_patch();
        cycle(0, 1, 0, d);
        repeat (6) cycle(0, 0, 1, d);
        cycle(1, 0, 1, d);
        chk("rst_mid", {spk_pixels, frame_start, busy, done, step_cnt}, 64'h0);
        repeat (4) cycle(0, 0, 1, d);

        // Random traffic, including loads mid-window and data churn without load.
        for (int n = 0; n < 600; n++) begin
            bit r, l, p;
            r = ($urandom_range(0, 99) < 1);
            l = ($urandom_range(0, 99) < 4);
            p = ($urandom_range(0, 99) < 55);
            cycle(r, l, p, rand_patch());
        end

        cycle(0, 0, 0, '0);
        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never checked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
